// File: rtl/key_reduction_ctrl_if.sv
// Bus bundle between the key loader, the reduction datapath and the consumer.
// master drives the key words, the reduced key and the consumer handshake;
// slave is the controller side.
interface key_reduction_ctrl_if;
    logic         abort;
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_data;
    logic         wr_last;
    logic [511:0] key_bus;
    logic         red_start;
    logic [15:0]  red_key_in;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_key;
    logic         err;
    logic         busy;

    modport master (
        output abort, wr_valid, wr_data, wr_last, red_key_in, out_ready,
        input  wr_ready, key_bus, red_start, out_valid, out_key, err, busy
    );

    modport slave (
        input  abort, wr_valid, wr_data, wr_last, red_key_in, out_ready,
        output wr_ready, key_bus, red_start, out_valid, out_key, err, busy
    );
endinterface

// File: rtl/key_reduction_ctrl.sv
// Key reduction controller: assembles sixteen 32-bit key words into a 512-bit
// key, launches the external reduction datapath, waits LAT cycles (1..15) for
// its result, and presents the 16-bit reduced key on a valid/ready output.
// The assembled key is zeroized as soon as it is no longer needed.
module key_reduction_ctrl #(
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    key_reduction_ctrl_if.slave bus
);
    localparam int         DATA_W    = 32;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] WAIT      = 3'd3;
    localparam logic [2:0] HOLD      = 3'd4;
    localparam logic [3:0] LAST_WORD = 4'd15;
    localparam logic [3:0] WAIT_LAST = 4'(LAT - 1);

    logic [2:0]   state;
    logic [3:0]   word_cnt;
    logic [3:0]   wait_cnt;
    logic [511:0] key_q;
    logic [15:0]  out_key_q;
    logic         err_q;
    logic         wr_ready_int;
    logic         accept;
    logic         frame_bad;

    // Ready is gated by rst_n so it stays low for the whole reset and rises
    // as soon as reset is released.
    assign wr_ready_int = rst_n & ((state == IDLE) | (state == LOAD));
    assign accept       = bus.wr_valid & wr_ready_int;
    // wr_last must be set on word 15 and only on word 15.
    assign frame_bad    = bus.wr_last != (word_cnt == LAST_WORD);

    assign bus.wr_ready  = wr_ready_int;
    assign bus.key_bus   = key_q;
    assign bus.red_start = (state == RUN);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_key   = out_key_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);

    // Main sequencer: word assembly, launch, wait, capture and output hold.
    // abort overrides every transition but leaves out_key and err alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            wait_cnt  <= '0;
            key_q     <= '0;
            out_key_q <= '0;
            err_q     <= 1'b0;
        end else if (bus.abort) begin
            state    <= IDLE;
            word_cnt <= '0;
            wait_cnt <= '0;
            key_q    <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (frame_bad) begin
                            err_q    <= 1'b1;
                            key_q    <= '0;
                            word_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            key_q[{word_cnt, 5'd0} +: DATA_W] <= bus.wr_data;
                            // Wraps back to zero after word 15.
                            word_cnt <= word_cnt + 4'd1;
                            if (state == IDLE) begin
                                err_q <= 1'b0;
                            end
                            state <= (word_cnt == LAST_WORD) ? RUN : LOAD;
                        end
                    end
                end
                RUN: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        out_key_q <= bus.red_key_in;
                        key_q     <= '0;
                        wait_cnt  <= '0;
                        state     <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    word_cnt <= '0;
                    wait_cnt <= '0;
                    key_q    <= '0;
                end
            endcase
        end
    end
endmodule
